// File: rtl/raggedstone_spinn_aer_if_led_driver_pkg.sv
// Shared encodings for the AER interface LED driver.
// Mode select values, activity FSM states and counter width.
package raggedstone_spinn_aer_if_led_driver_pkg;

    localparam int CNT_W = 20;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'b00,
        MODE_ON    = 2'b01,
        MODE_BLINK = 2'b10,
        MODE_ACT   = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ON   = 2'b01,
        ST_GAP  = 2'b10
    } state_e;

endpackage

// File: rtl/raggedstone_spinn_aer_if_led_driver_reload_cnt.sv
// Down-counter with synchronous reload, decrement enable, zero flag.
// Ports: clk, rst (async active-low), load, dec -> zero.
module raggedstone_spinn_aer_if_reload_cnt
    import raggedstone_spinn_aer_if_led_driver_pkg::*;
#(
    parameter logic [CNT_W-1:0] RELOAD = '1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    output logic zero
);

    logic [CNT_W-1:0] cnt;

    // A counter at zero reloads instead of wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= RELOAD;
        end else if (load || (dec && zero)) begin
            cnt <= RELOAD;
        end else if (dec) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/raggedstone_spinn_aer_if_led_driver.sv
// Status LED driver: off / on / blink / activity-stretch modes.
// Ports: clk, rst (async active-low), mode, event_in -> led_out, busy.
module raggedstone_spinn_aer_if_led_driver
    import raggedstone_spinn_aer_if_led_driver_pkg::*;
#(
    parameter logic [CNT_W-1:0] STRETCH_CONST = 20'hfffff,
    parameter logic [CNT_W-1:0] BLINK_CONST   = 20'hfffff,
    parameter logic             LED_ON_LEVEL  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] mode,
    input  logic       event_in,
    output logic       led_out,
    output logic       busy
);

    mode_e  mode_q;
    state_e state_q;
    state_e state_d;
    logic   pend_q;
    logic   pend_d;
    logic   phase_q;
    logic   led_q;
    logic   busy_q;
    logic   lit_d;
    logic   busy_d;
    logic   mode_chg;
    logic   s_load;
    logic   s_dec;
    logic   s_zero;
    logic   b_load;
    logic   b_dec;
    logic   b_zero;

    assign mode_chg = (mode_e'(mode) != mode_q);

    raggedstone_spinn_aer_if_reload_cnt #(
        .RELOAD(STRETCH_CONST)
    ) u_stretch (
        .clk (clk),
        .rst (rst),
        .load(s_load),
        .dec (s_dec),
        .zero(s_zero)
    );

    raggedstone_spinn_aer_if_reload_cnt #(
        .RELOAD(BLINK_CONST)
    ) u_blink (
        .clk (clk),
        .rst (rst),
        .load(b_load),
        .dec (b_dec),
        .zero(b_zero)
    );

    assign s_dec  = (state_q != ST_IDLE);
    assign b_dec  = (mode_q == MODE_BLINK);
    assign b_load = mode_chg || (b_dec && b_zero);

    // State register plus mode copy, pending flag and blink phase.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q  <= MODE_OFF;
            state_q <= ST_IDLE;
            pend_q  <= 1'b0;
            phase_q <= 1'b1;
            led_q   <= ~LED_ON_LEVEL;
            busy_q  <= 1'b0;
        end else begin
            mode_q  <= mode_e'(mode);
            state_q <= state_d;
            pend_q  <= pend_d;
            led_q   <= lit_d ? LED_ON_LEVEL : ~LED_ON_LEVEL;
            busy_q  <= busy_d;
            if (mode_chg) begin
                phase_q <= 1'b1;
            end else if (b_dec && b_zero) begin
                phase_q <= ~phase_q;
            end
        end
    end

    // Activity FSM next state; leaving or entering a mode aborts it.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        s_load  = 1'b0;
        if (mode_chg || (mode_q != MODE_ACT)) begin
            state_d = ST_IDLE;
            pend_d  = 1'b0;
            s_load  = mode_chg;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (event_in) begin
                        state_d = ST_ON;
                        s_load  = 1'b1;
                    end
                end
                ST_ON: begin
                    pend_d = pend_q | event_in;
                    if (s_zero) begin
                        state_d = ST_GAP;
                        s_load  = 1'b1;
                    end
                end
                ST_GAP: begin
                    if (!s_zero) begin
                        pend_d = pend_q | event_in;
                    end else if (pend_q || event_in) begin
                        // Back-to-back pulse, no IDLE cycle between.
                        state_d = ST_ON;
                        s_load  = 1'b1;
                        pend_d  = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    pend_d  = 1'b0;
                end
            endcase
        end
    end

    // Output decode; the change edge itself drives dark.
    always_comb begin
        lit_d  = 1'b0;
        busy_d = (state_d != ST_IDLE);
        if (!mode_chg) begin
            unique case (mode_q)
                MODE_OFF:   lit_d = 1'b0;
                MODE_ON:    lit_d = 1'b1;
                MODE_BLINK: lit_d = phase_q;
                MODE_ACT:   lit_d = (state_d == ST_ON);
                default:    lit_d = 1'b0;
            endcase
        end
    end

    assign led_out = led_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_raggedstone_spinn_aer_if_led_driver.sv
// Table-driven bench for the AER interface LED driver.
// STRETCH_CONST=3, BLINK_CONST=2, LED_ON_LEVEL=1.
module tb_raggedstone_spinn_aer_if_led_driver;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] mode = 2'b00;
    logic       event_in = 1'b0;
    logic       led_out;
    logic       busy;
    int         n_cmp = 0;
    int         n_bad = 0;

    raggedstone_spinn_aer_if_led_driver #(
        .STRETCH_CONST(20'd3),
        .BLINK_CONST  (20'd2),
        .LED_ON_LEVEL (1'b1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .mode    (mode),
        .event_in(event_in),
        .led_out (led_out),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] mode;
        logic       ev;
        logic       led;
        logic       busy;
        string      tag;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic [1:0] m, input logic e,
                       input logic l, input logic b,
                       input int n, input string t);
        for (int i = 0; i < n; i++) begin
            vec_t v;
            v.mode = m;
            v.ev   = e;
            v.led  = l;
            v.busy = b;
            v.tag  = t;
            vq.push_back(v);
        end
    endtask

    task automatic check(input string t, input logic act,
                         input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b want %b", t, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // single pulse
        add(3, 0, 0, 0, 1, "act_chg");
        add(3, 0, 0, 0, 1, "act_idle");
        add(3, 1, 1, 1, 1, "single_ev");
        add(3, 0, 1, 1, 3, "single_on");
        add(3, 0, 0, 1, 4, "single_gap");
        add(3, 0, 0, 0, 3, "single_idle");
        // burst collapses to one extra pulse
        add(3, 1, 1, 1, 4, "burst_ev");
        add(3, 0, 0, 1, 4, "burst_gap1");
        add(3, 0, 1, 1, 4, "burst_on2");
        add(3, 0, 0, 1, 4, "burst_gap2");
        add(3, 0, 0, 0, 2, "burst_idle");
        // event at the GAP terminal edge
        add(3, 1, 1, 1, 1, "edge_ev");
        add(3, 0, 1, 1, 3, "edge_on");
        add(3, 0, 0, 1, 4, "edge_gap");
        add(3, 1, 1, 1, 1, "edge_reon");
        add(3, 0, 1, 1, 3, "edge_on2");
        add(3, 0, 0, 1, 4, "edge_gap2");
        add(3, 0, 0, 0, 2, "edge_idle");
        // blink
        add(2, 0, 0, 0, 1, "blk_chg");
        add(2, 0, 1, 0, 3, "blk_on");
        add(2, 0, 0, 0, 3, "blk_off");
        add(2, 0, 1, 0, 2, "blk_on2");
        add(0, 0, 0, 0, 2, "blk_to_off");
        add(2, 0, 0, 0, 1, "blk_chg2");
        add(2, 0, 1, 0, 3, "blk_restart");
        add(2, 0, 0, 0, 1, "blk_off2");
        // activity aborted by a mode change
        add(3, 0, 0, 0, 1, "abort_chg");
        add(3, 1, 1, 1, 1, "abort_ev");
        add(3, 0, 1, 1, 1, "abort_on");
        // steady on / off ignore events
        add(1, 0, 0, 0, 1, "on_chg");
        add(1, 1, 1, 0, 3, "on_ev");
        add(1, 0, 1, 0, 1, "on_hold");
        add(0, 0, 0, 0, 1, "off_chg");
        add(0, 1, 0, 0, 2, "off_ev");

        rst      = 1'b0;
        mode     = 2'b00;
        event_in = 1'b0;
        #2;
        check("rst_led", led_out, 1'b0);
        check("rst_busy", busy, 1'b0);
        step();
        step();
        check("rst_led_hold", led_out, 1'b0);
        rst = 1'b1;
        step();
        check("post_rst_led", led_out, 1'b0);

        for (int i = 0; i < vq.size(); i++) begin
            mode     = vq[i].mode;
            event_in = vq[i].ev;
            step();
            check($sformatf("%s[%0d].led", vq[i].tag, i),
                  led_out, vq[i].led);
            check($sformatf("%s[%0d].busy", vq[i].tag, i),
                  busy, vq[i].busy);
        end

        // async reset in the middle of an ON pulse
        mode     = 2'b11;
        event_in = 1'b0;
        step();
        step();
        event_in = 1'b1;
        step();
        event_in = 1'b1;
        step();
        event_in = 1'b0;
        check("arst_pre_led", led_out, 1'b1);
        check("arst_pre_busy", busy, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        check("arst_led", led_out, 1'b0);
        check("arst_busy", busy, 1'b0);
        step();
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check($sformatf("arst_after[%0d].led", i), led_out, 1'b0);
            check($sformatf("arst_after[%0d].busy", i), busy, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
